// File: rtl/prio_encode_arb.sv
// prio_encode_arb: registered N-input priority encoder with a valid/ready
// output handshake. A winner is chosen by searching downward from a priority
// pointer (wrapping N-1 after 0) and held until the consumer accepts it.
//
// Build option: define PRIO_ENCODE_ARB_ROUND_ROBIN_EN to make the pointer a
// register that moves just below each winner (round-robin fairness). Without
// it the pointer is the constant N-1 (fixed highest-index-first priority).
//
// Handshake: valid_o/code_o/grant_o form one result. A result is accepted on a
// rising edge where valid_o=1 and ready_i=1; on that same edge the next result
// (or valid_o=0) is loaded. While valid_o=1 and ready_i=0 every output is
// frozen and req is ignored. ready_i has no effect while valid_o=0.
module prio_encode_arb #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] code_o,
  output logic [N-1:0] grant_o,
  output logic         z_o
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [W-1:0] PTR_RST = W'(N - 1);

  state_e       state_q, state_d;
  logic         valid_q, valid_d;
  logic [W-1:0] code_q, code_d;
  logic [N-1:0] grant_q, grant_d;
  logic         z_q, z_d;

  logic [W-1:0] ptr;
  logic [W-1:0] cand;
  logic [W-1:0] win_idx;
  logic         win_found;
  logic         sample;
  logic         load;

  // A new sample is taken every IDLE cycle and on each accepted HOLD cycle.
  assign sample = (state_q == IDLE) || ready_i;
  assign load   = sample && win_found;

  // Downward search from ptr; the lowest distance k is visited last so it wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = W'((int'(ptr) - k + N) % N);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef PRIO_ENCODE_ARB_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;

  // Move the pointer just below the new winner so it becomes lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = (win_idx == '0) ? PTR_RST : (win_idx - W'(1));
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PTR_RST;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = PTR_RST;
`endif

  // Next-state and next-output logic; everything holds unless a sample occurs.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    grant_d = grant_q;
    z_d     = z_q;
    if (sample) begin
      z_d = (req == '0);
      if (win_found) begin
        state_d = HOLD;
        valid_d = 1'b1;
        code_d  = win_idx;
        grant_d = {{(N - 1){1'b0}}, 1'b1} << win_idx;
      end else begin
        state_d = IDLE;
        valid_d = 1'b0;
        grant_d = '0;
      end
    end
  end

  // State and output registers; outputs come only from here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      code_q  <= '0;
      grant_q <= '0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      grant_q <= grant_d;
      z_q     <= z_d;
    end
  end

  assign valid_o = valid_q;
  assign code_o  = code_q;
  assign grant_o = grant_q;
  assign z_o     = z_q;

endmodule
